class_value_enum: RTL

//  Inverse of the value classifiers (is_zero / is_less_than_two style predicates).
//  - Classifiers map a WIDTH-bit value to a class bit.
//  - This block maps a requested class to a stream of WIDTH-bit values belonging to it:

---
 rtl/class_enum_pkg.sv | 14 +
 rtl/value_classifier.sv | 16 +
 rtl/class_value_enum.sv | 117 +++++++++++
 3 files changed

// File: rtl/class_enum_pkg.sv
// rtl/class_enum_pkg.sv - shared types, class constants and class-size helper for the value enumerator
package class_enum_pkg;

  typedef enum logic {IDLE, EMIT} state_e;

  localparam logic CLASS_LO = 1'b0;
  localparam logic CLASS_HI = 1'b1;

  // Number of distinct values in a class: [0, thresh) or [thresh, 2**width).
  function automatic int class_size(input logic cls, input int width, input int thresh);
    return (cls == CLASS_HI) ? ((1 << width) - thresh) : thresh;
  endfunction

endpackage

// File: rtl/value_classifier.sv
// rtl/value_classifier.sv - combinational class predicate: is_hi_o = in_i >= THRESH
module value_classifier
  import class_enum_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int THRESH = 2
) (
  input  logic [WIDTH-1:0] in_i,
  output logic             is_hi_o
);

  localparam logic [WIDTH-1:0] THR = WIDTH'(THRESH);

  assign is_hi_o = (in_i >= THR);

endmodule

// File: rtl/class_value_enum.sv
// rtl/class_value_enum.sv - emits a stream of values belonging to a requested class, with self-check
module class_value_enum
  import class_enum_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int THRESH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_class,
  input  logic [WIDTH:0]   req_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_last,
  output logic             chk_err
);

  if (THRESH < 1 || THRESH > (1 << WIDTH) - 1) begin : g_bad_thresh
    $error("class_value_enum: THRESH out of range 1 .. 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] LO_MAX = WIDTH'(THRESH - 1);
  localparam logic [WIDTH-1:0] HI_MIN = WIDTH'(THRESH);
  localparam logic [WIDTH-1:0] HI_MAX = '1;
  localparam logic [WIDTH:0]   REM_ONE  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   SIZE_LO  = (WIDTH+1)'(class_size(CLASS_LO, WIDTH, THRESH));
  localparam logic [WIDTH:0]   SIZE_HI  = (WIDTH+1)'(class_size(CLASS_HI, WIDTH, THRESH));

  state_e           state_q, state_d;
  logic             cls_q, cls_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] cur0_q, cur0_d;
  logic [WIDTH-1:0] cur1_q, cur1_d;
  logic             chk_err_q, chk_err_d;

  logic             accept;
  logic             beat_xfer;
  logic             is_last;
  logic             is_hi;

  assign accept    = (state_q == IDLE) && req_valid;
  assign is_last   = (rem_q == REM_ONE);
  assign beat_xfer = (state_q == EMIT) && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)               state_d = EMIT;
      EMIT:    if (beat_xfer && is_last) state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    out_valid = (state_q == EMIT);
    out_value = '0;
    out_last  = 1'b0;
    if (state_q == EMIT) begin
      out_value = cls_q ? cur1_q : cur0_q;
      out_last  = is_last;
    end
    chk_err = chk_err_q;
  end

  value_classifier #(.WIDTH(WIDTH), .THRESH(THRESH)) u_check (
    .in_i    (out_value),
    .is_hi_o (is_hi)
  );

  // Cursors compare against their class bound before incrementing so wrap never relies on overflow.
  always_comb begin
    cls_d     = cls_q;
    rem_d     = rem_q;
    cur0_d    = cur0_q;
    cur1_d    = cur1_q;
    chk_err_d = chk_err_q;
    if (accept) begin
      cls_d = req_class;
      if (req_len != '0)            rem_d = req_len;
      else if (req_class == CLASS_HI) rem_d = SIZE_HI;
      else                          rem_d = SIZE_LO;
    end
    if (beat_xfer) begin
      rem_d = rem_q - REM_ONE;
      if (cls_q == CLASS_HI) cur1_d = (cur1_q == HI_MAX) ? HI_MIN : cur1_q + ONE;
      else                   cur0_d = (cur0_q == LO_MAX) ? '0     : cur0_q + ONE;
    end
    if (out_valid && (is_hi != cls_q)) chk_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cls_q     <= CLASS_LO;
      rem_q     <= '0;
      cur0_q    <= '0;
      cur1_q    <= HI_MIN;
      chk_err_q <= 1'b0;
    end else begin
      cls_q     <= cls_d;
      rem_q     <= rem_d;
      cur0_q    <= cur0_d;
      cur1_q    <= cur1_d;
      chk_err_q <= chk_err_d;
    end
  end

endmodule
